// File: rtl/knap_pkg.sv
// Shared item tables, feasibility limits and sweep FSM encoding for the knapsack sweeper.
package knap_pkg;

    localparam int TABLE_ITEMS = 12;

    localparam int MIN_VALUE  = 107;
    localparam int MAX_WEIGHT = 60;
    localparam int MAX_VOLUME = 60;

    // Index 0 is item A, index 11 is item L.
    localparam int ITEM_VALUE  [TABLE_ITEMS] = '{ 4,  8,  0, 20, 10, 12, 18, 14,  6, 15, 30,  8};
    localparam int ITEM_WEIGHT [TABLE_ITEMS] = '{28,  8, 27, 18, 27, 28,  6,  1, 20,  0,  5, 13};
    localparam int ITEM_VOLUME [TABLE_ITEMS] = '{27, 27,  4,  4,  0, 24,  4, 20, 12, 15,  5,  2};

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/knap_eval.sv
// Combinational totals and feasibility for one selection vector (bit0 = item A).
module knap_eval
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 12,
    parameter int SUM_W   = 10
) (
    input  logic [N_ITEMS-1:0] sel,
    output logic [SUM_W-1:0]   value,
    output logic [SUM_W-1:0]   weight,
    output logic [SUM_W-1:0]   volume,
    output logic               feasible
);

    always_comb begin
        value  = '0;
        weight = '0;
        volume = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                value  = value  + SUM_W'(ITEM_VALUE[i]);
                weight = weight + SUM_W'(ITEM_WEIGHT[i]);
                volume = volume + SUM_W'(ITEM_VOLUME[i]);
            end
        end
    end

    // All three limits are inclusive.
    assign feasible = (value  >= SUM_W'(MIN_VALUE))  &&
                      (weight <= SUM_W'(MAX_WEIGHT)) &&
                      (volume <= SUM_W'(MAX_VOLUME));

endmodule

// File: rtl/knap_sweep.sv
// Exhaustive knapsack sweep over all 2^N_ITEMS selections, streaming feasible hits.
// Best-candidate tracking is built only when KNAP_BEST_TRACK_EN is defined.
module knap_sweep
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 12,
    parameter int SUM_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               hit_valid_o,
    input  logic               hit_ready_i,
    output logic [N_ITEMS-1:0] hit_sel_o,
    output logic [N_ITEMS:0]   hit_count_o,
    output logic [N_ITEMS-1:0] best_sel_o,
    output logic [SUM_W-1:0]   best_value_o,
    output state_t             state_dbg
);

    state_t             state, state_next;
    logic [N_ITEMS-1:0] counter;
    logic [SUM_W-1:0]   eval_value, eval_weight, eval_volume;
    logic               eval_feasible;
    logic               run, accept, stall, load, advance, last;

    knap_eval #(.N_ITEMS(N_ITEMS), .SUM_W(SUM_W)) u_eval (
        .sel      (counter),
        .value    (eval_value),
        .weight   (eval_weight),
        .volume   (eval_volume),
        .feasible (eval_feasible)
    );

    // Handshake: a hit transfers on any rising edge where hit_valid_o && hit_ready_i;
    // hit_sel_o is held stable while hit_valid_o is high and not yet accepted.
    assign run     = (state == ST_RUN);
    assign accept  = hit_valid_o && hit_ready_i;
    assign stall   = run && eval_feasible && hit_valid_o && !hit_ready_i;
    assign load    = run && eval_feasible && !stall;
    assign advance = run && !stall;
    assign last    = &counter;

    assign busy_o    = (state == ST_RUN) || (state == ST_DRAIN);
    assign done_o    = (state == ST_DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start_i) state_next = ST_RUN;
            ST_RUN:   if (advance && last) state_next = ST_DRAIN;
            ST_DRAIN: if (!hit_valid_o) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter     <= '0;
            hit_valid_o <= 1'b0;
            hit_sel_o   <= '0;
            hit_count_o <= '0;
        end else begin
            if (state == ST_IDLE && start_i) begin
                counter     <= '0;
                hit_count_o <= '0;
            end
            // The counter parks on the last candidate rather than wrapping.
            if (advance && !last) counter <= counter + 1'b1;
            if (load) begin
                hit_sel_o   <= counter;
                hit_valid_o <= 1'b1;
                hit_count_o <= hit_count_o + 1'b1;
            end else if (accept) begin
                hit_valid_o <= 1'b0;
            end
        end
    end

`ifdef KNAP_BEST_TRACK_EN
    logic unused_sums;
    assign unused_sums = ^{eval_weight, eval_volume};

    // Strictly-greater keeps the lower-index candidate on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sel_o   <= '0;
            best_value_o <= '0;
        end else if (state == ST_IDLE && start_i) begin
            best_sel_o   <= '0;
            best_value_o <= '0;
        end else if (load && (eval_value > best_value_o)) begin
            best_sel_o   <= counter;
            best_value_o <= eval_value;
        end
    end
`else
    logic unused_sums;
    assign unused_sums  = ^{eval_value, eval_weight, eval_volume};
    assign best_sel_o   = '0;
    assign best_value_o = '0;
`endif

endmodule

// File: doc/knap_sweep.md
KNAP_SWEEP -- requirements
Module: knap_sweep

Interface
REQ-001 SHALL have parameter N_ITEMS, default 12: item count; candidate width and sweep length 2^N_ITEMS.
REQ-002 SHALL have parameter SUM_W, default 10: width of the value, weight and volume accumulators; no wrap for 12 items.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start_i  in  1  begin a sweep; sampled in IDLE only.
REQ-006 SHALL have port busy_o  out  1  high in RUN and DRAIN.
REQ-007 SHALL have port done_o  out  1  one-cycle pulse at sweep end.
REQ-008 SHALL have port hit_valid_o  out  1  hit_sel_o holds a feasible candidate.
REQ-009 SHALL have port hit_ready_i  in  1  consumer accepts the hit when high with hit_valid_o.
REQ-010 SHALL have port hit_sel_o  out  N_ITEMS  feasible selection vector; bit0 = item A.
REQ-011 SHALL have port hit_count_o  out  N_ITEMS+1  feasible candidates found this sweep.
REQ-012 SHALL have port best_sel_o / best_value_o  out  N_ITEMS / SUM_W  highest-value feasible candidate and its value.

Function
REQ-013 SHALL use a one-hot FSM with states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN on start_i; SHALL clear the counter, hit_count_o and best_* on that edge.
REQ-015 In RUN, SHALL evaluate candidate sel = counter each cycle: totals = sum of selected per-item value/weight/volume at SUM_W bits.
REQ-016 A candidate SHALL be feasible iff value >= MIN_VALUE, weight <= MAX_WEIGHT and volume <= MAX_VOLUME; boundaries are inclusive.
REQ-017 A feasible candidate SHALL load the output register with one cycle of latency and set hit_valid_o.
REQ-018 hit_valid_o SHALL stay high with hit_sel_o stable until hit_valid_o && hit_ready_i.
REQ-019 The counter SHALL stall while the current candidate is feasible and the output register is full and not being drained that cycle; accept-and-reload in the same cycle SHALL be allowed.
REQ-020 hit_count_o SHALL increment once per feasible candidate loaded; it SHALL NOT double-count during a stall.
REQ-021 After candidate 2^N_ITEMS-1 is evaluated, the FSM SHALL enter DRAIN; the counter SHALL NOT wrap to 0.
REQ-022 DRAIN->DONE SHALL occur once hit_valid_o is low; DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-023 start_i in RUN, DRAIN or DONE SHALL be ignored.
REQ-024 hit_count_o and best_* SHALL hold their final values in IDLE until the next start.

Reset
REQ-025 rst SHALL force IDLE immediately, including mid-sweep; any pending hit SHALL be discarded.
REQ-026 On reset, all outputs SHALL be 0: busy_o, done_o, hit_valid_o, hit_sel_o, hit_count_o, best_sel_o and best_value_o.

Configuration
REQ-027 With KNAP_BEST_TRACK_EN defined, best_* SHALL update on a feasible candidate with value strictly greater than best_value_o; ties SHALL keep the earlier (lower-index) candidate.
REQ-028 Without KNAP_BEST_TRACK_EN, best_* SHALL be tied to 0 and no comparator SHALL be synthesised.

Structure
REQ-029 A shared package knap_pkg SHALL hold the item tables (value/weight/volume per item) and the limits MIN_VALUE=107, MAX_WEIGHT=60, MAX_VOLUME=60.
REQ-030 The package SHALL use the item table below (value, weight, volume):
- A 4,28,27; B 8,8,27; C 0,27,4; D 20,18,4; E 10,27,0; F 12,28,24
- G 18,6,4; H 14,1,20; I 6,20,12; J 15,0,15; K 30,5,5; L 8,13,2
REQ-031 Totals and feasibility SHALL be computed in one combinational sub-module knap_eval (sel in; value, weight, volume and feasible out); knap_sweep instantiates it once.

Verification
REQ-032 knap_eval with sel=0x6D8 (D,E,G,H,J,K) -> value 107, weight 57, volume 48; feasible=1 (min-value boundary).
REQ-033 knap_eval with sel=0x6C8 (0x6D8 without E) -> value 97; feasible=0. With sel=0xED8 (0x6D8 plus L) -> weight 70; feasible=0.
REQ-034 Full sweep with hit_ready_i=1 -> done_o asserted in the 4097th or 4098th cycle after start; the hit stream, hit_count_o and best_* equal a software model over all 4096 selections.
REQ-035 Full sweep with hit_ready_i random at 30% -> identical hit sequence and count, with no hit lost or duplicated.
REQ-036 Assert rst while sweeping at counter 0x400 -> all outputs 0 on the next cycle; a new start gives results identical to a clean sweep.
REQ-037 start_i pulsed while busy_o=1 -> no restart; hit_count_o is unaffected.
